// File: rtl/uart_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_boot_loader_pkg
// Shared types and constants for the UART boot loader and its receiver.
//   boot_state_t : top-level loader FSM states (IDLE .. ERR)
//   rx_state_t   : 8N1 receiver states
//   LEN_BYTES    : number of little-endian bytes in the word-count header
//   WORD_BYTES   : number of bytes per memory word
//   clks_per_bit : clock cycles per UART bit for a given clock and baud rate
// -----------------------------------------------------------------------------
package uart_boot_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LEN,
      RECV,
      WRITE,
      DONE,
      ERR
   } boot_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   // Integer divide; any fractional remainder is a baud error the link tolerates.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_boot_loader_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a 2-flop input synchronizer.
//   clk        : system clock
//   reset      : asynchronous, active-low
//   rx_line    : raw UART line, idle high, asynchronous to clk
//   byte_valid : 1-cycle pulse when a frame with a good stop bit completes
//   data_byte  : received byte, valid while byte_valid is high
//   frame_err  : 1-cycle pulse when the stop bit is sampled low
// Parameter CLKS_PER_BIT sets the bit period in clock cycles.
// -----------------------------------------------------------------------------
module uart_rx
   import uart_boot_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_line,
   output logic       byte_valid,
   output logic [7:0] data_byte,
   output logic       frame_err
);

   // Guard against a zero half-period for very small bit periods.
   localparam int HALF_BIT = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

   logic        rx_meta;
   logic        rx_sync;
   logic        rx_prev;
   rx_state_t   rx_state;
   logic [15:0] clk_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;

   // Two-flop synchronizer plus one extra stage for falling-edge detection.
   // All reset to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_line;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Bit-timing counter and deserializer. The start bit is re-checked at half
   // a bit period so short glitches drop back to idle silently. Data bits are
   // shifted in LSB first, then the stop bit decides between a good byte and a
   // framing error. The state is back in RX_IDLE on the cycle after the stop
   // sample, at the same time the result pulse appears.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state   <= RX_IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         data_byte  <= '0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               clk_cnt <= '0;
               if (rx_prev && !rx_sync) begin
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (clk_cnt == 16'(HALF_BIT - 1)) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  if (!rx_sync) begin
                     rx_state <= RX_DATA;
                  end else begin
                     rx_state <= RX_IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (clk_cnt == 16'(CLKS_PER_BIT - 1)) begin
                  clk_cnt   <= '0;
                  shift_reg <= {rx_sync, shift_reg[7:1]};
                  if (bit_idx == 3'd7) begin
                     rx_state <= RX_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (clk_cnt == 16'(CLKS_PER_BIT - 1)) begin
                  clk_cnt  <= '0;
                  rx_state <= RX_IDLE;
                  if (rx_sync) begin
                     byte_valid <= 1'b1;
                     data_byte  <= shift_reg;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_boot_loader.sv
// -----------------------------------------------------------------------------
// uart_boot_loader
// Receives a program image over UART and writes it word-by-word into BRAM,
// holding the CPU in reset until the image is complete.
// Image format: 2-byte little-endian word count N, then N little-endian words.
//   clk            : system clock
//   reset          : asynchronous, active-low
//   RxD            : raw UART RX line
//   load_req       : debounced button level, rising edge starts a load
//   mem_address    : byte address of the current write (word aligned)
//   mem_write_data : word being written
//   mem_write_en   : 1-cycle write strobe
//   cpu_hold       : CPU held in reset, memory port owned by the loader
//   busy           : high while waiting for the header or receiving words
//   error          : sticky framing / length error flag
//   words_loaded   : words written in the current load
// -----------------------------------------------------------------------------
module uart_boot_loader
   import uart_boot_loader_pkg::*;
#(
   parameter int CLK_HZ       = 100000000,
   parameter int BAUD         = 115200,
   parameter int NUM_OF_BYTES = 800
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RxD,
   input  logic        load_req,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_en,
   output logic        cpu_hold,
   output logic        busy,
   output logic        error,
   output logic [15:0] words_loaded
);

   localparam int          CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
   localparam logic [15:0] MAX_WORDS    = 16'(NUM_OF_BYTES / WORD_BYTES);

   boot_state_t state;
   logic        load_prev;
   logic        load_rise;
   logic        restart;
   logic [1:0]  byte_idx;
   logic [7:0]  len_lo;
   logic [15:0] word_count;
   logic [15:0] len_value;
   logic [23:0] word_buf;
   logic        byte_valid;
   logic [7:0]  data_byte;
   logic        frame_err;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_rx (
      .clk       (clk),
      .reset     (reset),
      .rx_line   (RxD),
      .byte_valid(byte_valid),
      .data_byte (data_byte),
      .frame_err (frame_err)
   );

   // A load request is only honoured from the resting states. Evaluating it
   // ahead of the byte handling makes a restart win over a simultaneous byte.
   always_comb begin
      load_rise = load_req && !load_prev;
      restart   = load_rise && ((state == IDLE) || (state == DONE) || (state == ERR));
      len_value = {data_byte, len_lo};
   end

   // Loader FSM with registered outputs. The last byte of a word launches the
   // write strobe directly, so the strobe is high exactly while in WRITE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         load_prev      <= 1'b0;
         byte_idx       <= '0;
         len_lo         <= '0;
         word_count     <= '0;
         word_buf       <= '0;
         mem_address    <= '0;
         mem_write_data <= '0;
         mem_write_en   <= 1'b0;
         cpu_hold       <= 1'b1;
         busy           <= 1'b0;
         error          <= 1'b0;
         words_loaded   <= '0;
      end else begin
         load_prev    <= load_req;
         mem_write_en <= 1'b0;
         if (restart) begin
            state        <= WAIT_LEN;
            error        <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
            mem_address  <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  cpu_hold <= 1'b1;
                  busy     <= 1'b0;
               end
               WAIT_LEN: begin
                  if (frame_err) begin
                     state <= ERR;
                     error <= 1'b1;
                     busy  <= 1'b0;
                  end else if (byte_valid) begin
                     if (byte_idx == 2'(LEN_BYTES - 2)) begin
                        len_lo   <= data_byte;
                        byte_idx <= byte_idx + 2'd1;
                     end else begin
                        byte_idx <= '0;
                        if ((len_value == 16'd0) || (len_value > MAX_WORDS)) begin
                           state <= ERR;
                           error <= 1'b1;
                           busy  <= 1'b0;
                        end else begin
                           word_count <= len_value;
                           state      <= RECV;
                        end
                     end
                  end
               end
               RECV: begin
                  if (frame_err) begin
                     state <= ERR;
                     error <= 1'b1;
                     busy  <= 1'b0;
                  end else if (byte_valid) begin
                     case (byte_idx)
                        2'd0: word_buf[7:0]   <= data_byte;
                        2'd1: word_buf[15:8]  <= data_byte;
                        2'd2: word_buf[23:16] <= data_byte;
                        default: begin
                           mem_write_en   <= 1'b1;
                           mem_write_data <= {data_byte, word_buf};
                           mem_address    <= {14'b0, words_loaded, 2'b00};
                           state          <= WRITE;
                        end
                     endcase
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
               WRITE: begin
                  words_loaded <= words_loaded + 16'd1;
                  if ((words_loaded + 16'd1) == word_count) begin
                     state    <= DONE;
                     cpu_hold <= 1'b0;
                     busy     <= 1'b0;
                  end else begin
                     state <= RECV;
                  end
               end
               DONE: begin
                  cpu_hold <= 1'b0;
                  busy     <= 1'b0;
               end
               ERR: begin
                  error    <= 1'b1;
                  cpu_hold <= 1'b1;
                  busy     <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
